// File: rtl/hex_page_sequencer.sv
// Snapshots a 32-bit value and pages it onto a 16-bit seven-segment bus,
// alternating halves on a dwell timer or by manual select.
// Optional: define HEX_PAGE_CHANGE_FLAG_EN for the new-value flag pulse.
module hex_page_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned FLAG_CYCLES  = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        auto_en,
  input  logic        manual_sel,
  input  logic        freeze,
  output logic [15:0] page_data,
  output logic        page_sel,
  output logic        new_flag
);

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("hex_page_sequencer: DWELL_CYCLES must be at least 2");
  end
  if (FLAG_CYCLES == 0) begin : g_bad_flag
    $error("hex_page_sequencer: FLAG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AUTO_LO = 2'd1,
    AUTO_HI = 2'd2,
    MANUAL  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_nxt;
  logic [31:0]        snap;
  logic               snap_load;
  logic               dwell_wrap;
  logic               in_auto;

  assign in_auto    = (state == AUTO_LO) || (state == AUTO_HI);
  assign dwell_wrap = (dwell_cnt == DWELL_LAST) && !freeze;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = auto_en ? AUTO_LO : MANUAL;
        snap_load = !freeze;
      end
      AUTO_LO: begin
        if (!auto_en)        state_nxt = MANUAL;
        else if (dwell_wrap) state_nxt = AUTO_HI;
      end
      AUTO_HI: begin
        // Reloading only when returning to the low page keeps both halves
        // of one lo/hi pass from the same 32-bit value.
        if (!auto_en) begin
          state_nxt = MANUAL;
        end else if (dwell_wrap) begin
          state_nxt = AUTO_LO;
          snap_load = 1'b1;
        end
      end
      MANUAL: begin
        snap_load = !freeze;
        if (auto_en) state_nxt = AUTO_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A page change always restarts the dwell count; the wrap itself is a
  // page change, so the counter never runs past DWELL_LAST.
  always_comb begin
    dwell_nxt = dwell_cnt;
    if (state_nxt != state)       dwell_nxt = '0;
    else if (in_auto && !freeze)  dwell_nxt = dwell_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      snap      <= '0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      if (snap_load) snap <= data_in;
    end
  end

  assign page_sel  = (state == AUTO_HI) || ((state == MANUAL) && manual_sel);
  assign page_data = page_sel ? snap[31:16] : snap[15:0];

`ifdef HEX_PAGE_CHANGE_FLAG_EN
  localparam int unsigned FLAG_W = $clog2(FLAG_CYCLES + 1);

  logic [FLAG_W-1:0] flag_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_cnt <= '0;
    end else if (snap_load && (data_in != snap)) begin
      flag_cnt <= FLAG_W'(FLAG_CYCLES);
    end else if (flag_cnt != '0) begin
      flag_cnt <= flag_cnt - 1'b1;
    end
  end

  assign new_flag = (flag_cnt != '0);
`else
  assign new_flag = 1'b0;
`endif

endmodule
